cn_roundkey_sequencer: RTL and testbench
========================================

CN_ROUNDKEY_SEQUENCER -- requirements
Module: cn_roundkey_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 10, giving the number of 128-bit round keys captured per expansion (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_l, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new expansion of key.
REQ-005 The block SHALL have port key, input, 256 bits: the AES-256 cipher key; [255:128] is the first 128 bits in byte order.
REQ-006 The block SHALL have port ke_run, output, 2 bits: run control to the key-expansion stage (0 hold, 1 load first half, 2 load second half, 3 iterate).
REQ-007 The block SHALL have port ke_cipherkey, output, 128 bits: key half presented to the key-expansion stage.
REQ-008 The block SHALL have port ke_roundkeys, input, 128 bits: current round key from the key-expansion stage.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a load or expansion is in progress.
REQ-010 The block SHALL have port keys_valid, output, 1 bit: high when all NUM_KEYS round keys are stored.
REQ-011 The block SHALL have port rd_idx, input, 4 bits: round-key read index.
REQ-012 The block SHALL have port rd_key, output, 128 bits: stored round key rd_idx, combinational read.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD_LO, LOAD_HI, EXPAND and READY.
REQ-014 In IDLE or READY, start=1 SHALL register key into an internal 256-bit holding register, clear keys_valid and move to LOAD_LO on the next edge.
REQ-015 start SHALL be ignored in LOAD_LO, LOAD_HI and EXPAND; the holding register SHALL NOT change.
REQ-016 In LOAD_LO, the block SHALL drive ke_run=1 and ke_cipherkey=hold[255:128], then move to LOAD_HI.
REQ-017 In LOAD_HI, the block SHALL drive ke_run=2 and ke_cipherkey=hold[127:0], then move to EXPAND with counter cnt=0.
REQ-018 In EXPAND, on each edge, the block SHALL write ke_roundkeys into store[cnt] and increment cnt.
REQ-019 In EXPAND, ke_run SHALL be 3 while cnt<NUM_KEYS-1 and 0 when cnt=NUM_KEYS-1.
REQ-020 After store[NUM_KEYS-1] is written, the FSM SHALL enter READY with keys_valid=1.
REQ-021 In IDLE and READY, ke_run SHALL be 0; ke_cipherkey SHALL be 0 outside LOAD_LO and LOAD_HI.
REQ-022 busy SHALL be 1 exactly in LOAD_LO, LOAD_HI and EXPAND.
REQ-023 Latency: with start sampled at edge 0, keys_valid SHALL first read 1 after edge NUM_KEYS+3 (edge 13 at default).
REQ-024 Total iterate pulses (ke_run=3) per expansion SHALL be exactly NUM_KEYS-1.
REQ-025 rd_key SHALL equal store[rd_idx] when rd_idx<NUM_KEYS, and 0 otherwise.
REQ-026 The store SHALL be readable in every state; it SHALL be written only in EXPAND.
REQ-027 start in READY SHALL drop keys_valid on the next edge; the old store contents SHALL stay readable until overwritten slot by slot.
REQ-028 cnt SHALL be 4 bits and SHALL never exceed NUM_KEYS-1.

Reset
REQ-029 When reset_l=0, the block SHALL asynchronously enter IDLE and clear cnt, the holding register, every store entry, ke_run, ke_cipherkey, busy and keys_valid to 0.
REQ-030 A reset during LOAD_LO, LOAD_HI or EXPAND SHALL abort the expansion; no partial keys_valid SHALL occur.
REQ-031 After reset release, the block SHALL need a new start before it asserts busy.

Verification
REQ-032 Basic expansion: with the real key-expansion stage attached, key=000102..1f and start pulsed, the bench SHALL check:
- store[0]=000102030405060708090a0b0c0d0e0f
- store[1]=101112131415161718191a1b1c1d1e1f
- store[2]=a573c29fa176c498a97fce93a572c09c
- store[3]=1651a8cd0244beda1a5da4c10640bade
- keys_valid=1 at edge 13.
REQ-033 Control trace: the bench SHALL check the ke_run sequence 1,2,3x9,0, and that ke_cipherkey equals the halves in order [255:128] then [127:0].
REQ-034 Start during busy: start=1 with a different key at edge 5 SHALL change neither the outputs nor the timing, and the store SHALL hold the first key's schedule.
REQ-035 Restart from READY: a new key started in READY SHALL drop keys_valid at the next edge and reassert it 13 edges after start, with the new store.
REQ-036 Mid-expansion reset: reset_l low in EXPAND with cnt=4 SHALL give busy=0, keys_valid=0, rd_key=0 for all idx, and ke_run=0 immediately.
REQ-037 Index bound: rd_idx=10..15 at default NUM_KEYS SHALL return rd_key=0.

Source files
------------

// File: rtl/cn_roundkey_sequencer.sv
// Sequences an AES-256 key through an external key-expansion stage and keeps
// the resulting NUM_KEYS round keys in a readable store.
module cn_roundkey_sequencer #(
  parameter int NUM_KEYS = 10
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         start,
  input  logic [255:0] key,
  output logic [1:0]   ke_run,
  output logic [127:0] ke_cipherkey,
  input  logic [127:0] ke_roundkeys,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    EXPAND  = 3'd3,
    READY   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);
  localparam logic [4:0] KEY_CNT  = 5'(NUM_KEYS);

  state_t         state_r;
  logic [3:0]     cnt_r;
  logic [255:0]   hold_r;
  logic           pend_r;
  logic [1:0]     ke_run_r;
  logic [127:0]   ke_cipherkey_r;
  logic           busy_r;
  logic           keys_valid_r;
  logic [127:0]   store_r [0:15];
  logic [127:0]   rd_key_s;

  // Sequencer FSM with registered control outputs. The start edge only
  // captures the key into hold_r; loading begins on the following edge so
  // that both halves are always presented from the holding register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      hold_r         <= 256'd0;
      pend_r         <= 1'b0;
      ke_run_r       <= 2'd0;
      ke_cipherkey_r <= 128'd0;
      busy_r         <= 1'b0;
      keys_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, READY: begin
          if (pend_r) begin
            state_r        <= LOAD_LO;
            pend_r         <= 1'b0;
            ke_run_r       <= 2'd1;
            ke_cipherkey_r <= hold_r[255:128];
            busy_r         <= 1'b1;
          end else if (start) begin
            hold_r       <= key;
            pend_r       <= 1'b1;
            keys_valid_r <= 1'b0;
          end else begin
            ke_run_r       <= 2'd0;
            ke_cipherkey_r <= 128'd0;
          end
        end
        LOAD_LO: begin
          state_r        <= LOAD_HI;
          ke_run_r       <= 2'd2;
          ke_cipherkey_r <= hold_r[127:0];
        end
        LOAD_HI: begin
          state_r        <= EXPAND;
          cnt_r          <= 4'd0;
          ke_run_r       <= (4'd0 < LAST_IDX) ? 2'd3 : 2'd0;
          ke_cipherkey_r <= 128'd0;
        end
        EXPAND: begin
          if (cnt_r == LAST_IDX) begin
            state_r      <= READY;
            cnt_r        <= 4'd0;
            ke_run_r     <= 2'd0;
            busy_r       <= 1'b0;
            keys_valid_r <= 1'b1;
          end else begin
            cnt_r    <= cnt_r + 4'd1;
            ke_run_r <= ((cnt_r + 4'd1) < LAST_IDX) ? 2'd3 : 2'd0;
          end
        end
        default: begin
          state_r        <= IDLE;
          cnt_r          <= 4'd0;
          pend_r         <= 1'b0;
          ke_run_r       <= 2'd0;
          ke_cipherkey_r <= 128'd0;
          busy_r         <= 1'b0;
          keys_valid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Round-key store: one slot per EXPAND cycle; slots at or above NUM_KEYS
  // are never written and stay zero.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < 16; i++) begin
        store_r[i] <= 128'd0;
      end
    end else begin
      if (state_r == EXPAND) begin
        store_r[cnt_r] <= ke_roundkeys;
      end
    end
  end

  // Combinational read port, zero beyond the configured key count.
  always_comb begin
    rd_key_s = 128'd0;
    if ({1'b0, rd_idx} < KEY_CNT) begin
      rd_key_s = store_r[rd_idx];
    end else begin
      rd_key_s = 128'd0;
    end
  end

  assign ke_run       = ke_run_r;
  assign ke_cipherkey = ke_cipherkey_r;
  assign busy         = busy_r;
  assign keys_valid   = keys_valid_r;
  assign rd_key       = rd_key_s;

endmodule

// File: tb/tb_cn_roundkey_sequencer.sv
// Bench for cn_roundkey_sequencer: an AES-256 key-expansion stage model drives
// ke_roundkeys; expectations come from the key schedule and the timing rules.
module tb_cn_roundkey_sequencer;

  localparam int N = 10;

  logic         clk;
  logic         reset_l;
  logic         start;
  logic [255:0] key;
  logic [1:0]   ke_run;
  logic [127:0] ke_cipherkey;
  logic [127:0] ke_roundkeys = 128'd0;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int checks   = 0;
  int failures = 0;
  logic [127:0] mdl [0:15];

  cn_roundkey_sequencer #(.NUM_KEYS(N)) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .key(key),
    .ke_run(ke_run), .ke_cipherkey(ke_cipherkey), .ke_roundkeys(ke_roundkeys),
    .busy(busy), .keys_valid(keys_valid), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AES arithmetic for the reference key schedule
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [127:0] aes_rk(input logic [255:0] k, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 4*r + 4; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Key-expansion stage model: load halves, then one round key per iterate.
  logic [255:0] stg_key;
  int           stg_idx;
  always @(posedge clk) begin
    case (ke_run)
      2'd1: stg_key[255:128] <= ke_cipherkey;
      2'd2: begin
        stg_key[127:0] <= ke_cipherkey;
        stg_idx        <= 0;
        ke_roundkeys   <= stg_key[255:128];
      end
      2'd3: begin
        stg_idx      <= stg_idx + 1;
        ke_roundkeys <= aes_rk(stg_key, stg_idx + 1);
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic read_chk(input string tag, input int idx);
    rd_idx = idx[3:0];
    #1;
    chk(tag, rd_key, mdl[idx]);
  endtask

  // One expansion from the start edge (e=0) to keys_valid (e=N+3).
  task automatic run_exp(input logic [255:0] k, input bit inject);
    logic [1:0]   exp_run;
    logic [127:0] exp_ck;
    start = 1'b1; key = k;
    step();
    start = 1'b0; key = rand_key();
    for (int e = 0; e <= N + 3; e++) begin
      if (e >= 4 && e - 4 < N) mdl[e-4] = aes_rk(k, e - 4);
      exp_run = (e == 1) ? 2'd1 : (e == 2) ? 2'd2 : (e >= 3 && e < N + 2) ? 2'd3 : 2'd0;
      exp_ck  = (e == 1) ? k[255:128] : (e == 2) ? k[127:0] : 128'd0;
      chk("ke_run", {126'd0, ke_run}, {126'd0, exp_run});
      chk("ke_cipherkey", ke_cipherkey, exp_ck);
      chk("busy", {127'd0, busy}, {127'd0, (e >= 1 && e <= N + 2)});
      chk("keys_valid", {127'd0, keys_valid}, {127'd0, (e == N + 3)});
      read_chk("rd_key_live", $urandom_range(0, 15));
      if (e < N + 3) begin
        if (inject && e == 4) begin
          start = 1'b1; key = rand_key();
        end
        step();
        start = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++) read_chk("rd_key_sweep", i);
  endtask

  initial begin
    logic [255:0] k;
    reset_l = 1'b0; start = 1'b0; key = 256'd0; rd_idx = 4'd0;
    for (int i = 0; i < 16; i++) mdl[i] = 128'd0;
    #2;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_valid", {127'd0, keys_valid}, 128'd0);
    chk("rst_ke_run", {126'd0, ke_run}, 128'd0);
    chk("rst_cipherkey", ke_cipherkey, 128'd0);
    read_chk("rst_rd_key", 0);
    @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", {127'd0, busy}, 128'd0);
      chk("idle_ke_run", {126'd0, ke_run}, 128'd0);
    end

    // Known vector with a start request injected while busy.
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_exp(k, 1'b1);
    rd_idx = 4'd0; #1; chk("vec_store0", rd_key, 128'h000102030405060708090a0b0c0d0e0f);
    rd_idx = 4'd1; #1; chk("vec_store1", rd_key, 128'h101112131415161718191a1b1c1d1e1f);
    rd_idx = 4'd2; #1; chk("vec_store2", rd_key, 128'ha573c29fa176c498a97fce93a572c09c);
    rd_idx = 4'd3; #1; chk("vec_store3", rd_key, 128'h1651a8cd0244beda1a5da4c10640bade);
    for (int i = N; i < 16; i++) begin
      rd_idx = i[3:0]; #1; chk("idx_bound", rd_key, 128'd0);
    end

    // Restarts from READY with random keys; old slots stay visible until rewritten.
    run_exp(rand_key(), 1'b0);
    run_exp(rand_key(), 1'b1);

    // Reset while expanding at cnt=4.
    k = rand_key();
    start = 1'b1; key = k;
    step();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    chk("mid_ke_run", {126'd0, ke_run}, 128'd3);
    reset_l = 1'b0;
    #1;
    chk("mid_busy", {127'd0, busy}, 128'd0);
    chk("mid_valid", {127'd0, keys_valid}, 128'd0);
    chk("mid_ke_run_rst", {126'd0, ke_run}, 128'd0);
    chk("mid_cipherkey", ke_cipherkey, 128'd0);
    for (int i = 0; i < 16; i++) mdl[i] = 128'd0;
    for (int i = 0; i < 16; i++) read_chk("mid_rd_key", i);
    @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_busy", {127'd0, busy}, 128'd0);
      chk("post_rst_valid", {127'd0, keys_valid}, 128'd0);
    end

    run_exp(rand_key(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
